// File: rtl/key_event_if.sv
// Bundle between the key press-timing stage and the gesture classifier:
// confirmed edge strobes and press duration in, gesture events out.
// master: the side that drives the key strobes; slave: the classifier.
interface key_event_if;
    logic        key_flag;
    logic        key_state;
    logic [9:0]  dur;
    logic        evt_valid;
    logic [1:0]  evt_code;
    logic [11:0] evt_cnt;
    logic [6:0]  codeout;

    modport master (
        output key_flag, key_state, dur,
        input  evt_valid, evt_code, evt_cnt, codeout
    );

    modport slave (
        input  key_flag, key_state, dur,
        output evt_valid, evt_code, evt_cnt, codeout
    );
endinterface

// File: rtl/key_event_classifier.sv
// Gesture classifier: turns confirmed press/release strobes plus press
// duration into single / double / long events, counts events in 3-digit BCD
// and drives one active-low 7-segment digit with the last gesture.
// Optional feature macro: KEY_DBL_CLICK_EN (double-click detection with a
// release-to-press gap timer). Without it, every short click is a single.
module key_event_classifier #(
    parameter int TICK_DIV = 500_000,   // clk cycles per 10 ms gap tick
    parameter int LONG_TH  = 100,       // long press threshold, 10 ms units
    parameter int DBL_GAP  = 30         // max gap in ticks for a double click
) (
    input  logic       clk,
    input  logic       rst,
    key_event_if.slave bus
);

    localparam logic [9:0] LONG_TH_W   = 10'(LONG_TH);
    localparam logic [1:0] CODE_SINGLE = 2'b01;
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
    localparam logic [1:0] CODE_LONG   = 2'b11;
    localparam logic [6:0] SEG_DASH    = 7'b0111111;
    localparam logic [6:0] SEG_ONE     = 7'b1111001;
    localparam logic [6:0] SEG_TWO     = 7'b0100100;
    localparam logic [6:0] SEG_L       = 7'b1000111;

    // Reject configurations the fixed-width datapath cannot represent.
    if (TICK_DIV < 1 || TICK_DIV > (1 << 19) || LONG_TH < 0 || LONG_TH > 1023
        || DBL_GAP < 1) begin : g_bad_cfg
        $error("key_event_classifier: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        GAP    = 2'd2,
        PRESS2 = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        press_stb;
    logic        release_stb;
    logic        is_long;
    logic        emit;
    logic [1:0]  emit_code;

    assign press_stb   = bus.key_flag && !bus.key_state;
    assign release_stb = bus.key_flag &&  bus.key_state;
    assign is_long     = (bus.dur >= LONG_TH_W);

`ifdef KEY_DBL_CLICK_EN
    // gap counter is at least 6 bits, wider if DBL_GAP needs it
    localparam int             GW        = ($clog2(DBL_GAP + 1) > 6) ? $clog2(DBL_GAP + 1) : 6;
    localparam logic [18:0]    TICK_LAST = 19'(TICK_DIV - 1);
    localparam logic [GW-1:0]  GAP_END   = GW'(DBL_GAP);

    logic [18:0]   presc_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          gap_clr;
    logic          timeout;

    assign timeout = (gap_cnt_reg == GAP_END);

    // Gap timer: prescaled 10 ms ticks counted only while waiting in GAP.
    always_ff @(posedge clk) begin
        if (rst || gap_clr) begin
            presc_reg   <= '0;
            gap_cnt_reg <= '0;
        end else if (state_reg == GAP) begin
            if (presc_reg == TICK_LAST) begin
                presc_reg   <= '0;
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end
`endif

    // Gesture FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Gesture FSM next-state and event decision.
    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        emit_code  = 2'b00;
`ifdef KEY_DBL_CLICK_EN
        gap_clr    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (press_stb) begin
                    state_next = PRESS1;
                end
            end
            PRESS1: begin
                if (release_stb) begin
                    if (is_long) begin
                        emit       = 1'b1;
                        emit_code  = CODE_LONG;
                        state_next = IDLE;
                    end else begin
`ifdef KEY_DBL_CLICK_EN
                        gap_clr    = 1'b1;
                        state_next = GAP;
`else
                        emit       = 1'b1;
                        emit_code  = CODE_SINGLE;
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef KEY_DBL_CLICK_EN
            GAP: begin
                // a second press on the timeout cycle still counts as a double
                if (press_stb) begin
                    state_next = PRESS2;
                end else if (timeout) begin
                    emit       = 1'b1;
                    emit_code  = CODE_SINGLE;
                    state_next = IDLE;
                end
            end
            PRESS2: begin
                if (release_stb) begin
                    emit       = 1'b1;
                    emit_code  = is_long ? CODE_LONG : CODE_DOUBLE;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // BCD event counter: digit gi steps when every lower digit wraps 9 -> 0.
    logic [11:0] cnt_reg;
    logic [11:0] cnt_next;
    logic [2:0]  carry;

    assign carry[0] = emit;

    for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
        assign cnt_next[gi*4 +: 4] = !carry[gi]                 ? cnt_reg[gi*4 +: 4] :
                                     (cnt_reg[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                                                   cnt_reg[gi*4 +: 4] + 4'd1;
        if (gi < 2) begin : g_carry
            assign carry[gi+1] = carry[gi] && (cnt_reg[gi*4 +: 4] == 4'd9);
        end
    end

    function automatic logic [6:0] seg_of(input logic [1:0] code);
        case (code)
            CODE_SINGLE: seg_of = SEG_ONE;
            CODE_DOUBLE: seg_of = SEG_TWO;
            CODE_LONG:   seg_of = SEG_L;
            default:     seg_of = SEG_DASH;
        endcase
    endfunction

    logic       evt_valid_reg;
    logic [1:0] evt_code_reg;
    logic [6:0] codeout_reg;

    // Event outputs: pulse, code, count and display all update on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_reg <= 1'b0;
            evt_code_reg  <= 2'b00;
            cnt_reg       <= '0;
            codeout_reg   <= SEG_DASH;
        end else begin
            evt_valid_reg <= emit;
            cnt_reg       <= cnt_next;
            if (emit) begin
                evt_code_reg <= emit_code;
                codeout_reg  <= seg_of(emit_code);
            end
        end
    end

    assign bus.evt_valid = evt_valid_reg;
    assign bus.evt_code  = evt_code_reg;
    assign bus.evt_cnt   = cnt_reg;
    assign bus.codeout   = codeout_reg;

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench for key_event_classifier. Stimulus pushes the expected
// event into a queue; a monitor pops and compares on every evt_valid pulse.
// Expectations follow KEY_DBL_CLICK_EN the same way the design does.
module tb_key_event_classifier;

    localparam int TICK_DIV = 10;
    localparam int LONG_TH  = 100;
    localparam int DBL_GAP  = 30;
    localparam int N_GAP    = TICK_DIV * DBL_GAP;

    typedef struct {
        logic [1:0]  code;
        logic [11:0] cnt;
        logic [6:0]  seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   total_events = 0;
    logic [1:0] last_code = 2'b00;

    always #5 clk = ~clk;

    key_event_if bus ();

    key_event_classifier #(
        .TICK_DIV (TICK_DIV),
        .LONG_TH  (LONG_TH),
        .DBL_GAP  (DBL_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] bcd3(input int n);
        int m;
        m = n % 1000;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [6:0] seg_for(input logic [1:0] code);
        case (code)
            2'b01:   return 7'b1111001;
            2'b10:   return 7'b0100100;
            2'b11:   return 7'b1000111;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic expect_event(input logic [1:0] code);
        exp_t e;
        total_events++;
        last_code = code;
        e.code = code;
        e.cnt  = bcd3(total_events);
        e.seg  = seg_for(code);
        sb.push_back(e);
    endtask

    // Monitor: every event pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.evt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %b cnt %03h, required no event",
                         bus.evt_code, bus.evt_cnt);
            end else begin
                e = sb.pop_front();
                $display("event t=%0t code=%b cnt=%03h seg=%b (exp %b %03h %b)", $time,
                         bus.evt_code, bus.evt_cnt, bus.codeout, e.code, e.cnt, e.seg);
                check("evt_code", 32'(bus.evt_code), 32'(e.code));
                check("evt_cnt",  32'(bus.evt_cnt),  32'(e.cnt));
                check("codeout",  32'(bus.codeout),  32'(e.seg));
            end
        end
    end

    // Called at a negedge; drives one strobe, returns at the next negedge.
    task automatic strobe(input logic st, input logic [9:0] d);
        bus.key_flag  = 1'b1;
        bus.key_state = st;
        bus.dur       = d;
        @(negedge clk);
        bus.key_flag  = 1'b0;
        bus.key_state = 1'b0;
        bus.dur       = '0;
    endtask

    task automatic press();
        strobe(1'b0, 10'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(bus.evt_valid), 32'd0);
        check({tag, "_code"},    32'(bus.evt_code),  32'd0);
        check({tag, "_cnt"},     32'(bus.evt_cnt),   32'h000);
        check({tag, "_codeout"}, 32'(bus.codeout),   32'(7'b0111111));
    endtask

    task automatic long_click(input logic [9:0] d);
        press();
        expect_event(2'b11);
        strobe(1'b1, d);
        check("long_latency", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
    endtask

`ifdef KEY_DBL_CLICK_EN
    task automatic double_click(input logic [9:0] d2, input logic [1:0] code);
        press();
        strobe(1'b1, 10'd20);
        repeat (5 * TICK_DIV) @(negedge clk);
        press();
        expect_event(code);
        strobe(1'b1, d2);
        check("double_latency", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
    endtask
`else
    task automatic short_click(input logic [9:0] d);
        press();
        expect_event(2'b01);
        strobe(1'b1, d);
        check("single_latency", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
    endtask
`endif

    initial begin
        bus.key_flag  = 1'b0;
        bus.key_state = 1'b0;
        bus.dur       = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

`ifdef KEY_DBL_CLICK_EN
        // short click with no follow-up: single exactly DBL_GAP ticks later
        press();
        strobe(1'b1, 10'd20);
        repeat (N_GAP) @(negedge clk);
        check("single_not_early", 32'(bus.evt_valid), 32'd0);
        expect_event(2'b01);
        @(negedge clk);
        check("single_on_time", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
`else
        short_click(10'd20);
`endif
        // long press
        long_click(10'd150);

        // threshold boundary: 99 is short, 100 is long
`ifdef KEY_DBL_CLICK_EN
        double_click(10'd99, 2'b10);
        double_click(10'd100, 2'b11);
        // second press on the timeout cycle preempts the single
        press();
        strobe(1'b1, 10'd20);
        repeat (N_GAP) @(negedge clk);
        bus.key_flag  = 1'b1;
        bus.key_state = 1'b0;
        @(negedge clk);
        bus.key_flag  = 1'b0;
        repeat (3) @(negedge clk);
        expect_event(2'b10);
        strobe(1'b1, 10'd20);
        check("preempt_latency", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
        // reset while in GAP drops the pending click
        press();
        strobe(1'b1, 10'd20);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        total_events = 0;
        last_code = 2'b00;
        repeat (N_GAP + 30) @(negedge clk);
`else
        short_click(10'd99);
        long_click(10'd100);
        // two fast clicks give two singles
        short_click(10'd20);
        short_click(10'd20);
        // reset mid-gesture, then the stray release is ignored in IDLE
        press();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        total_events = 0;
        last_code = 2'b00;
        strobe(1'b1, 10'd20);
        repeat (5) @(negedge clk);
        check("stray_release", 32'(bus.evt_cnt), 32'h000);
`endif

        // count up to 999, then one more wraps to 000
        while (total_events % 1000 != 999) long_click(10'd150);
        check("cnt_at_999", 32'(bus.evt_cnt), 32'h999);
        long_click(10'd200);
        check("cnt_wrap", 32'(bus.evt_cnt), 32'h000);

        // outputs hold between events
        repeat (5) @(negedge clk);
        check("hold_valid", 32'(bus.evt_valid), 32'd0);
        check("hold_code", 32'(bus.evt_code), 32'(last_code));
        check("hold_codeout", 32'(bus.codeout), 32'(seg_for(last_code)));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
